// File: rtl/vid_mem_arbiter.sv
// OAM/VRAM video-memory slave with PPU-mode lockout, in-order posted-write queue and an unblocked renderer port.
// Optional VID_MEM_FWD_EN: unlocked CPU reads return the newest matching queued write instead of RAM.
module vid_mem_arbiter #(
    parameter int                ADDR_W     = 16,
    parameter int                DATA_W     = 8,
    parameter logic [ADDR_W-1:0] OAM_BASE   = 16'hFE00,
    parameter int                OAM_SIZE   = 160,
    parameter logic [ADDR_W-1:0] VRAM_BASE  = 16'h8000,
    parameter int                VRAM_SIZE  = 8192,
    parameter int                WQ_DEPTH   = 4,
    parameter logic [DATA_W-1:0] LOCKED_VAL = '1
) (
    input  logic                         clk,
    input  logic                         reset_n,
    input  logic [1:0]                   ppu_mode,
    input  logic [ADDR_W-1:0]            cpu_addr,
    input  logic [DATA_W-1:0]            cpu_wdata,
    input  logic                         cpu_we,
    input  logic                         cpu_re,
    output logic                         cpu_sel,
    output logic [DATA_W-1:0]            cpu_rdata,
    output logic                         cpu_rvalid,
    input  logic                         ren_sel,
    input  logic [$clog2(VRAM_SIZE)-1:0] ren_addr,
    input  logic                         ren_re,
    output logic [DATA_W-1:0]            ren_rdata,
    output logic [$clog2(WQ_DEPTH):0]    wq_count,
    output logic                         wq_ovf,
    input  logic                         ovf_clr
);

    localparam int RA_W = $clog2(VRAM_SIZE);
    localparam int OA_W = $clog2(OAM_SIZE);
    localparam int QA_W = $clog2(WQ_DEPTH);

    localparam logic [ADDR_W:0] OAM_LO  = {1'b0, OAM_BASE};
    localparam logic [ADDR_W:0] OAM_HI  = OAM_LO + (ADDR_W+1)'(OAM_SIZE);
    localparam logic [ADDR_W:0] VRAM_LO = {1'b0, VRAM_BASE};
    localparam logic [ADDR_W:0] VRAM_HI = VRAM_LO + (ADDR_W+1)'(VRAM_SIZE);

    // region bit follows ren_sel encoding: 1 = OAM, 0 = VRAM
    typedef struct packed {
        logic              region;
        logic [RA_W-1:0]   off;
        logic [DATA_W-1:0] dat;
    } wq_ent_t;

    logic [DATA_W-1:0] oam_mem  [OAM_SIZE];
    logic [DATA_W-1:0] vram_mem [VRAM_SIZE];
    wq_ent_t           wq_mem   [WQ_DEPTH];

    logic [DATA_W-1:0] cpu_rdata_q, ren_rdata_q;
    logic              cpu_rvalid_q;
    logic [QA_W-1:0]   wr_ptr_q, rd_ptr_q;
    logic [QA_W:0]     cnt_q, cnt_d;
    logic              ovf_q, ovf_d;

    logic [ADDR_W:0]   addr_x;
    logic              oam_hit, vram_hit;
    logic [RA_W-1:0]   cpu_off;
    logic              oam_lock, vram_lock, cpu_lock;
    logic              wq_empty, wq_full;
    wq_ent_t           head;
    logic              head_lock, pop, cpu_wr, direct, push_req, push, drop;
    logic              oam_we, vram_we;
    logic [OA_W-1:0]   oam_waddr;
    logic [RA_W-1:0]   vram_waddr;
    logic [DATA_W-1:0] oam_wdat, vram_wdat;
    logic [DATA_W-1:0] ram_rd, cpu_rd_val, ren_rd;
    logic [31:0]       ren_off;

    assign addr_x   = {1'b0, cpu_addr};
    assign oam_hit  = (addr_x >= OAM_LO) && (addr_x < OAM_HI);
    assign vram_hit = (addr_x >= VRAM_LO) && (addr_x < VRAM_HI);
    assign cpu_sel  = oam_hit || vram_hit;
    assign cpu_off  = oam_hit ? RA_W'(cpu_addr - OAM_BASE) : RA_W'(cpu_addr - VRAM_BASE);

    assign oam_lock  = ppu_mode[1];
    assign vram_lock = (ppu_mode == 2'd3);
    assign cpu_lock  = oam_hit ? oam_lock : vram_lock;

    assign wq_empty  = (cnt_q == '0);
    assign wq_full   = (cnt_q == (QA_W+1)'(WQ_DEPTH));
    assign head      = wq_mem[rd_ptr_q];
    assign head_lock = head.region ? oam_lock : vram_lock;
    assign pop       = !wq_empty && !head_lock;

    // Direct writes only bypass an empty queue, so they never collide with a drain.
    assign cpu_wr    = cpu_we && cpu_sel;
    assign direct    = cpu_wr && wq_empty && !cpu_lock;
    assign push_req  = cpu_wr && !direct;
    assign push      = push_req && (!wq_full || pop);
    assign drop      = push_req && wq_full && !pop;

    assign oam_we     = (pop && head.region) || (direct && oam_hit);
    assign oam_waddr  = pop ? head.off[OA_W-1:0] : cpu_off[OA_W-1:0];
    assign oam_wdat   = pop ? head.dat : cpu_wdata;
    assign vram_we    = (pop && !head.region) || (direct && !oam_hit);
    assign vram_waddr = pop ? head.off : cpu_off;
    assign vram_wdat  = pop ? head.dat : cpu_wdata;

    assign ram_rd = oam_hit ? oam_mem[cpu_off[OA_W-1:0]] : vram_mem[cpu_off];

`ifdef VID_MEM_FWD_EN
    logic              fwd_hit;
    logic [DATA_W-1:0] fwd_dat;
    logic [QA_W-1:0]   fwd_idx;

    // Walk oldest to newest so the last match is the most recent write.
    always_comb begin
        fwd_hit = 1'b0;
        fwd_dat = '0;
        fwd_idx = '0;
        for (int i = 0; i < WQ_DEPTH; i++) begin
            fwd_idx = rd_ptr_q + QA_W'(i);
            if (((QA_W+1)'(i) < cnt_q) && (wq_mem[fwd_idx].region == oam_hit) &&
                (wq_mem[fwd_idx].off == cpu_off)) begin
                fwd_hit = 1'b1;
                fwd_dat = wq_mem[fwd_idx].dat;
            end
        end
    end

    assign cpu_rd_val = fwd_hit ? fwd_dat : ram_rd;
`else
    assign cpu_rd_val = ram_rd;
`endif

    assign ren_off = 32'(ren_addr);
    always_comb begin
        ren_rd = LOCKED_VAL;
        if (ren_sel) begin
            if (ren_off < 32'(OAM_SIZE)) ren_rd = oam_mem[ren_addr[OA_W-1:0]];
        end else begin
            if (ren_off < 32'(VRAM_SIZE)) ren_rd = vram_mem[ren_addr];
        end
    end

    always_comb begin
        cnt_d = cnt_q;
        if (push && !pop)      cnt_d = cnt_q + (QA_W+1)'(1);
        else if (!push && pop) cnt_d = cnt_q - (QA_W+1)'(1);
    end

    // A same-cycle overflow keeps the flag set even while ovf_clr is high.
    always_comb begin
        ovf_d = ovf_q;
        if (drop)         ovf_d = 1'b1;
        else if (ovf_clr) ovf_d = 1'b0;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cpu_rdata_q  <= '0;
            cpu_rvalid_q <= 1'b0;
            ren_rdata_q  <= '0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            cnt_q        <= '0;
            ovf_q        <= 1'b0;
        end else begin
            cpu_rvalid_q <= cpu_re && cpu_sel;
            if (cpu_re && cpu_sel) cpu_rdata_q <= cpu_lock ? LOCKED_VAL : cpu_rd_val;
            if (ren_re)            ren_rdata_q <= ren_rd;
            if (push)              wr_ptr_q    <= wr_ptr_q + QA_W'(1);
            if (pop)               rd_ptr_q    <= rd_ptr_q + QA_W'(1);
            cnt_q <= cnt_d;
            ovf_q <= ovf_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) wq_mem[wr_ptr_q] <= '{region: oam_hit, off: cpu_off, dat: cpu_wdata};
    end

    always_ff @(posedge clk) begin
        if (oam_we) oam_mem[oam_waddr] <= oam_wdat;
    end

    always_ff @(posedge clk) begin
        if (vram_we) vram_mem[vram_waddr] <= vram_wdat;
    end

    assign cpu_rdata  = cpu_rdata_q;
    assign cpu_rvalid = cpu_rvalid_q;
    assign ren_rdata  = ren_rdata_q;
    assign wq_count   = cnt_q;
    assign wq_ovf     = ovf_q;

endmodule

// File: tb/tb_vid_mem_arbiter.sv
// Scoreboard bench for vid_mem_arbiter: read expectations are queued at issue time and
// popped by a negedge monitor whenever cpu_rvalid or a registered renderer read appears.
module tb_vid_mem_arbiter;

    logic        clk = 1'b0;
    logic        reset_n = 1'b1;
    logic [1:0]  ppu_mode = 2'd0;
    logic [15:0] cpu_addr = '0;
    logic [7:0]  cpu_wdata = '0;
    logic        cpu_we = 1'b0;
    logic        cpu_re = 1'b0;
    logic        cpu_sel;
    logic [7:0]  cpu_rdata;
    logic        cpu_rvalid;
    logic        ren_sel = 1'b0;
    logic [12:0] ren_addr = '0;
    logic        ren_re = 1'b0;
    logic [7:0]  ren_rdata;
    logic [2:0]  wq_count;
    logic        wq_ovf;
    logic        ovf_clr = 1'b0;

    vid_mem_arbiter dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .ppu_mode   (ppu_mode),
        .cpu_addr   (cpu_addr),
        .cpu_wdata  (cpu_wdata),
        .cpu_we     (cpu_we),
        .cpu_re     (cpu_re),
        .cpu_sel    (cpu_sel),
        .cpu_rdata  (cpu_rdata),
        .cpu_rvalid (cpu_rvalid),
        .ren_sel    (ren_sel),
        .ren_addr   (ren_addr),
        .ren_re     (ren_re),
        .ren_rdata  (ren_rdata),
        .wq_count   (wq_count),
        .wq_ovf     (wq_ovf),
        .ovf_clr    (ovf_clr)
    );

    always #5 clk = ~clk;

    int         n_vec = 0;
    int         n_err = 0;
    logic [7:0] cpu_exp_q[$];
    logic [7:0] ren_exp_q[$];
    logic       ren_chk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) ren_chk <= 1'b0;
        else          ren_chk <= ren_re;
    end

    always @(negedge clk) begin
        logic [7:0] e;
        if (reset_n) begin
            if (cpu_rvalid) begin
                if (cpu_exp_q.size() == 0) begin
                    check("cpu_rvalid_unexpected", 32'(cpu_rvalid), 32'd0);
                end else begin
                    e = cpu_exp_q.pop_front();
                    check("cpu_rdata", 32'(cpu_rdata), 32'(e));
                end
            end
            if (ren_chk && ren_exp_q.size() != 0) begin
                e = ren_exp_q.pop_front();
                check("ren_rdata", 32'(ren_rdata), 32'(e));
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic rd(input logic [15:0] a, input logic [7:0] e);
        cpu_addr = a;
        cpu_re   = 1'b1;
        cpu_exp_q.push_back(e);
        step();
        cpu_re = 1'b0;
    endtask

    task automatic wr(input logic [15:0] a, input logic [7:0] d);
        cpu_addr  = a;
        cpu_wdata = d;
        cpu_we    = 1'b1;
        step();
        cpu_we = 1'b0;
    endtask

    task automatic ren(input logic s, input logic [12:0] a, input logic [7:0] e);
        ren_sel  = s;
        ren_addr = a;
        ren_re   = 1'b1;
        ren_exp_q.push_back(e);
        step();
        ren_re = 1'b0;
    endtask

    task automatic sel_chk(input logic [15:0] a, input logic e);
        cpu_addr = a;
        #1;
        check("cpu_sel", 32'(cpu_sel), 32'(e));
    endtask

    logic [7:0] fwd_exp;

    initial begin
        // reset state
        #3 reset_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_cpu_rdata", 32'(cpu_rdata), 32'h0);
        check("rst_cpu_rvalid", 32'(cpu_rvalid), 32'h0);
        check("rst_ren_rdata", 32'(ren_rdata), 32'h0);
        check("rst_wq_count", 32'(wq_count), 32'h0);
        check("rst_wq_ovf", 32'(wq_ovf), 32'h0);
        reset_n = 1'b1;
        step();

        // mode 0 direct writes and read-back
        ppu_mode = 2'd0;
        wr(16'h8000, 8'hA5);
        wr(16'h8001, 8'h5A);
        wr(16'h8014, 8'h00);
        check("t1_wq_count", 32'(wq_count), 32'd0);
        rd(16'h8000, 8'hA5);

        // mode 2: OAM locked, VRAM open
        ppu_mode = 2'd2;
        rd(16'hFE10, 8'hFF);
        rd(16'h8001, 8'h5A);
        wr(16'hFE10, 8'h3C);
        check("t2_wq_count_push", 32'(wq_count), 32'd1);
        ppu_mode = 2'd0;
        step();
        check("t2_wq_count_drain", 32'(wq_count), 32'd0);
        rd(16'hFE10, 8'h3C);

        // mode 3: overflow, clear, set-wins-over-clear, full push with pop
        ppu_mode = 2'd3;
        for (int i = 0; i < 5; i++) wr(16'h8010 + 16'(i), 8'h11 + 8'(i));
        check("t3_wq_count_full", 32'(wq_count), 32'd4);
        check("t3_wq_ovf_set", 32'(wq_ovf), 32'd1);
        ovf_clr = 1'b1;
        step();
        ovf_clr = 1'b0;
        check("t3_wq_ovf_clr", 32'(wq_ovf), 32'd0);
        cpu_addr = 16'h8015; cpu_wdata = 8'h55; cpu_we = 1'b1; ovf_clr = 1'b1;
        step();
        cpu_we = 1'b0; ovf_clr = 1'b0;
        check("t3_ovf_set_wins", 32'(wq_ovf), 32'd1);
        ovf_clr = 1'b1;
        step();
        ovf_clr = 1'b0;
        check("t3_wq_ovf_clr2", 32'(wq_ovf), 32'd0);
        ppu_mode = 2'd0;
        wr(16'h8016, 8'h66);
        check("t3_full_push_pop", 32'(wq_count), 32'd4);
        repeat (4) step();
        check("t3_drained", 32'(wq_count), 32'd0);
        rd(16'h8010, 8'h11);
        rd(16'h8013, 8'h14);
        rd(16'h8014, 8'h00);
        rd(16'h8016, 8'h66);

        // in-order drain behind a locked OAM head
        ppu_mode = 2'd2;
        wr(16'hFE20, 8'h77);
        wr(16'h8020, 8'h88);
        check("t4_count_2", 32'(wq_count), 32'd2);
        step();
        check("t4_blocked", 32'(wq_count), 32'd2);
        ppu_mode = 2'd0;
        step();
        check("t4_count_1", 32'(wq_count), 32'd1);
        ren(1'b1, 13'h020, 8'h77);
        check("t4_count_0", 32'(wq_count), 32'd0);
        ren(1'b0, 13'h020, 8'h88);
        rd(16'hFE20, 8'h77);
        rd(16'h8020, 8'h88);

        // renderer during draw mode, concurrent locked CPU read
        ppu_mode  = 2'd3;
        ren_sel   = 1'b0;
        ren_addr  = 13'h000;
        ren_re    = 1'b1;
        ren_exp_q.push_back(8'hA5);
        rd(16'h8000, 8'hFF);
        ren_re = 1'b0;
        ren(1'b1, 13'd200, 8'hFF);
        ren(1'b1, 13'h020, 8'h77);
        ren_addr = 13'h001;
        step();
        step();
        check("t5_ren_hold", 32'(ren_rdata), 32'h77);

        // decode boundaries and unmapped accesses
        sel_chk(16'hFE10, 1'b1);
        sel_chk(16'hFE9F, 1'b1);
        sel_chk(16'hFEA0, 1'b0);
        sel_chk(16'h7FFF, 1'b0);
        sel_chk(16'h9FFF, 1'b1);
        sel_chk(16'hA000, 1'b0);
        sel_chk(16'hC000, 1'b0);
        cpu_addr = 16'hC000; cpu_wdata = 8'h12; cpu_re = 1'b1; cpu_we = 1'b1;
        step();
        cpu_re = 1'b0; cpu_we = 1'b0;
        check("t6_no_rvalid", 32'(cpu_rvalid), 32'd0);
        check("t6_no_push", 32'(wq_count), 32'd0);

        // read of a queued address while its region unlocks
        ppu_mode = 2'd0;
        wr(16'h8030, 8'h01);
        ppu_mode = 2'd3;
        wr(16'h8030, 8'h99);
        check("t6_fwd_queued", 32'(wq_count), 32'd1);
`ifdef VID_MEM_FWD_EN
        fwd_exp = 8'h99;
`else
        fwd_exp = 8'h01;
`endif
        ppu_mode = 2'd0;
        rd(16'h8030, fwd_exp);
        check("t6_fwd_drained", 32'(wq_count), 32'd0);
        rd(16'h8030, 8'h99);

        // reset mid-queue discards entries
        ppu_mode = 2'd3;
        wr(16'h8000, 8'hEE);
        wr(16'h8001, 8'hEF);
        check("t7_queued", 32'(wq_count), 32'd2);
        reset_n = 1'b0;
        #1;
        check("t7_rst_count", 32'(wq_count), 32'd0);
        step();
        reset_n  = 1'b1;
        ppu_mode = 2'd0;
        step();
        check("t7_after_rst_count", 32'(wq_count), 32'd0);
        rd(16'h8000, 8'hA5);
        rd(16'h8001, 8'h5A);

        repeat (3) step();
        check("cpu_sb_empty", 32'(cpu_exp_q.size()), 32'd0);
        check("ren_sb_empty", 32'(ren_exp_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/vid_mem_arbiter.md
Name: vid_mem_arbiter

Overview:
- Parametrised video-memory slave holding OAM and VRAM; successor to the fixed-map whizgraphics memory.
- CPU bus accesses are locked out by PPU mode, as on DMG hardware.
- Locked CPU writes go into a posted-write queue and drain in order once the target region unlocks.
- A dedicated renderer read port is never blocked.

Parameters:
ADDR_W, 16, CPU address width
DATA_W, 8, data width
OAM_BASE, 16'hFE00, OAM base address
OAM_SIZE, 160, OAM bytes
VRAM_BASE, 16'h8000, VRAM base address
VRAM_SIZE, 8192, VRAM bytes
WQ_DEPTH, 4, posted-write queue entries; power of 2, at least 2
LOCKED_VAL, all-ones, data returned for locked reads

Ports:
clk  in  1  clock
reset_n  in  1  asynchronous active-low reset
ppu_mode  in  2  0=HBLANK 1=VBLANK 2=OAM scan 3=draw
cpu_addr  in  ADDR_W  CPU address
cpu_wdata  in  DATA_W  CPU write data
cpu_we  in  1  write strobe, one cycle
cpu_re  in  1  read strobe, one cycle
cpu_sel  out  1  combinational: cpu_addr inside OAM or VRAM
cpu_rdata  out  DATA_W  read data
cpu_rvalid  out  1  read-data valid
ren_sel  in  1  0=VRAM, 1=OAM
ren_addr  in  clog2(VRAM_SIZE)  renderer offset within the selected region
ren_re  in  1  renderer read strobe
ren_rdata  out  DATA_W  renderer read data
wq_count  out  clog2(WQ_DEPTH)+1  queue occupancy
wq_ovf  out  1  sticky overflow flag
ovf_clr  in  1  clears wq_ovf

Behaviour:
- Reset (asynchronous, reset_n low): cpu_rdata=0, cpu_rvalid=0, ren_rdata=0, wq_count=0, wq_ovf=0; queue emptied. RAM contents are not reset.
- Reset asserted mid-drain discards all queued entries.
- Decode: offset = cpu_addr - base.
  - OAM hit: OAM_BASE <= addr < OAM_BASE+OAM_SIZE. VRAM hit likewise.
  - No hit: cpu_sel=0; reads and writes are ignored and cpu_rvalid stays 0.
- Lock rules:
  - OAM locked in modes 2 and 3.
  - VRAM locked in mode 3 only.
  - Lock is evaluated in the cycle of the strobe.
- CPU read (hit): cpu_rvalid pulses 1 the cycle after cpu_re.
  - Locked region: cpu_rdata = LOCKED_VAL.
  - Unlocked region: cpu_rdata = RAM[offset], sampled in the strobe cycle.
- CPU write (hit):
  - Direct RAM write only if the queue is empty and the region is unlocked.
  - Otherwise push {region, offset, data}; this preserves write order.
- Queue drain:
  - Pop at most one entry per cycle, only when the head entry's region is unlocked; the entry is written to RAM.
  - Strictly in order: a locked head blocks later unlocked entries.
  - A drain and a CPU push may occur in the same cycle.
  - The drain uses the region write port, so a same-cycle CPU write is always pushed, never written directly.
- Full queue:
  - Push while full with a same-cycle pop: accepted.
  - Push while full without a pop: dropped, wq_ovf set.
  - wq_ovf clears only on ovf_clr; set wins over a same-cycle ovf_clr.
- Renderer: ren_rdata = RAM[ren_sel][ren_addr] one cycle after ren_re, regardless of mode.
  - Offsets beyond the region size return LOCKED_VAL.
  - ren_rdata holds its value when ren_re=0.
- Simultaneous CPU read, renderer read and drain/CPU write in one cycle are all legal.
  - Same-address read during a write returns the old data (read-before-write).
- A mode change takes effect the next cycle; no access in flight is aborted.

Optional Feature:
VID_MEM_FWD_EN
- Defined: a CPU read to an unlocked region that matches queued entries returns the newest matching queued data, not RAM.
- Undefined: such reads return RAM contents, which may be stale until the drain completes.

Test Plan:
1. Reset, mode 0; write 8'hA5 to 16'h8000, read it back -> cpu_rvalid next cycle, cpu_rdata=8'hA5; wq_count stays 0.
2. Mode 2; read 16'hFE10 -> 8'hFF; read VRAM 16'h8001 -> RAM data; write 8'h3C to 16'hFE10 -> wq_count=1. Switch to mode 0 -> entry drains in 1 cycle, wq_count=0, read 16'hFE10 returns 8'h3C.
3. Mode 3; five writes to VRAM with WQ_DEPTH=4 -> wq_count=4, wq_ovf=1; the 5th write is lost after the drain. ovf_clr -> wq_ovf=0.
4. Mode 2; write OAM, then VRAM -> VRAM entry waits behind the locked OAM head; moving to mode 0 drains both in order over 2 cycles.
5. Mode 3; ren_sel=0, ren_addr=0 -> ren_rdata = VRAM[0] next cycle while the CPU concurrently reads 8'hFF.
6. Read 16'hC000 -> cpu_sel=0, no cpu_rvalid. With VID_MEM_FWD_EN, a mode 3->0 read of a queued address returns the queued value.
